decode_stage: RTL
=================

Name: decode_stage

Overview:
- Pipeline stage 2. It sits directly downstream of the fetch stage and consumes its IR/PC pair.
- Decodes the 16-bit instruction, reads the 16x16 register file it owns (write port driven by writeback), and sign-extends immediates.
- Detects load-use hazards and issues a registered operand bundle to execute.
- Generates the stall back to fetch, and handles flush and halt.

Parameters:
- REGS, 16, number of architectural registers (4-bit specifiers).
- WIDTH, 16, datapath / instruction width.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous, active-high reset.
- IRIN  input  16  instruction from fetch.
- PCIN  input  16  PC of IRIN.
- VALID_IN  input  1  IRIN/PCIN valid this cycle.
- FLUSH  input  1  branch taken in execute: squash the instruction being decoded.
- WB_EN  input  1  register write enable from writeback.
- WB_ADDR  input  4  write register.
- WB_DATA  input  16  write data.
- STALL_OUT  output  1  combinational. Fetch must hold IRIN/PCIN/VALID_IN while it is high.
- VALID_OUT  output  1  the registered bundle below is a real instruction.
- OP_OUT  output  4  opcode.
- RD_OUT  output  4  destination / data register specifier.
- A_OUT  output  16  operand A.
- B_OUT  output  16  operand B.
- IMM_OUT  output  16  sign-extended immediate.
- PC_OUT  output  16  PC of the issued instruction.
- HALT_OUT  output  1  sticky; the core has halted.

Behaviour:
- Fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0], imm4=[3:0].
- Opcodes and decode:
  - 0000 NOP: no sources.
  - 0001-0111 R-type: A=R[rs], B=R[rt], IMM=0.
  - 1000 ADDI: A=R[rd], IMM=sext(imm8).
  - 1001 LOAD: A=R[rs], IMM=sext(imm4).
  - 1010 STORE: A=R[rs], B=R[rd], IMM=sext(imm4).
  - 1011 BEQZ: A=R[rd], IMM=sext(imm8).
  - 1100 JUMP: IMM=sext(imm8), no sources.
  - 1101/1110 reserved: decoded as NOP with VALID_OUT=0.
  - 1111 HALT.
- Operands not listed for an opcode are 0.
- Register file:
  - R0 always reads 0; writes to R0 are ignored.
  - A write with WB_EN=1 commits at posedge.
  - A same-cycle read of WB_ADDR (nonzero) returns WB_DATA (write-through bypass).
- Latency: one cycle. An instruction accepted at edge N appears on the outputs after edge N.
- Load-use hazard:
  - Condition: VALID_OUT=1, OP_OUT=1001, RD_OUT!=0, and RD_OUT equals any source register of the current valid IRIN.
  - Response: STALL_OUT=1. Next edge issues a bubble (VALID_OUT=0, all bundle fields 0). The instruction is re-decoded the following cycle.
  - A stall never lasts more than one cycle per load.
- Bubbles: VALID_IN=0 issues a bubble. STALL_OUT is 0 unless hazard or halted.
- FLUSH:
  - At the edge, issues a bubble regardless of IRIN, and the held instruction is discarded.
  - STALL_OUT is forced 0 while FLUSH=1.
  - FLUSH has priority over stall and over halt decode.
- Halt:
  - A valid HALT without FLUSH issues a bubble and sets HALT_OUT=1.
  - From the next cycle: STALL_OUT=1 permanently, VALID_OUT=0, further IRIN ignored.
  - WB writes still commit, so in-flight instructions drain.
  - Only RST clears halt.
- Reset (sync, mid-operation included):
  - All outputs 0: VALID_OUT, HALT_OUT, STALL_OUT, and all bundle fields.
  - All registers cleared to 0.
  - Any pending hazard or halt state is cleared.
  - A WB write in the reset cycle is dropped.
- Simultaneous events:
  - WB write to the hazard register does not cancel the stall.
  - FLUSH together with RST: RST wins.

Test Plan:
1. Reset, then WB_EN=1 writing R3=0x1234. Next cycle IRIN=0x1530 (ADD r5,r3,r0) valid -> after edge: VALID_OUT=1, OP_OUT=1, RD_OUT=5, A_OUT=0x1234, B_OUT=0, PC_OUT=PCIN.
2. Write-through: same cycle WB R7=0xBEEF and IRIN=0x2170 (SUB r1,r7,r0) -> A_OUT=0xBEEF. Write R0=5, then read R0 -> 0.
3. Load-use hazard:
   - Setup: IRIN=0x9420 (LOAD r4,[r2+0]), then IRIN=0x1140 (ADD r1,r4,r0).
   - Response: STALL_OUT=1 for exactly one cycle, one bubble issued, then the ADD is issued. IRIN=0x1150 after the LOAD gives no stall.
4. Immediates:
   - IRIN=0x83F0 (ADDI r3,-16) -> IMM_OUT=0xFFF0.
   - IRIN=0x9218 (LOAD) -> IMM_OUT=0xFFF8.
   - IRIN=0x8A7F -> IMM_OUT=0x007F.
5. FLUSH during a load-use stall:
   - Response: STALL_OUT drops to 0 and the bubble is issued.
   - The held ADD is not issued later.
   - FLUSH with IRIN=0xF000 -> HALT_OUT stays 0.
6. IRIN=0xF000 valid -> bubble issued, HALT_OUT=1, STALL_OUT=1 thereafter. Later valid IRINs produce no VALID_OUT. RST -> all outputs 0 and the block decodes again.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - pipeline stage 2: instruction decode, register file, load-use hazard, flush and halt
module decode_stage #(
    parameter int REGS  = 16,
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IRIN,
    input  logic [WIDTH-1:0] PCIN,
    input  logic             VALID_IN,
    input  logic             FLUSH,
    input  logic             WB_EN,
    input  logic [3:0]       WB_ADDR,
    input  logic [WIDTH-1:0] WB_DATA,
    output logic             STALL_OUT,
    output logic             VALID_OUT,
    output logic [3:0]       OP_OUT,
    output logic [3:0]       RD_OUT,
    output logic [WIDTH-1:0] A_OUT,
    output logic [WIDTH-1:0] B_OUT,
    output logic [WIDTH-1:0] IMM_OUT,
    output logic [WIDTH-1:0] PC_OUT,
    output logic             HALT_OUT
);

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1001;
    localparam logic [3:0] OP_STORE = 4'b1010;
    localparam logic [3:0] OP_BEQZ  = 4'b1011;
    localparam logic [3:0] OP_JUMP  = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    logic [REGS-1:0][WIDTH-1:0] regs_q, regs_d;

    logic             valid_q, valid_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       rd_q, rd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             halt_q, halt_d;

    logic [3:0]       op_f, rd_f, rs_f, rt_f;
    logic [WIDTH-1:0] rd_val, rs_val, rt_val;
    logic [WIDTH-1:0] sext8, sext4;
    logic [WIDTH-1:0] a_dec, b_dec, imm_dec;
    logic             use_rs, use_rt, use_rd;
    logic             is_legal, is_halt;
    logic             hazard, issue;

    assign op_f  = IRIN[15:12];
    assign rd_f  = IRIN[11:8];
    assign rs_f  = IRIN[7:4];
    assign rt_f  = IRIN[3:0];
    assign sext8 = {{(WIDTH-8){IRIN[7]}}, IRIN[7:0]};
    assign sext4 = {{(WIDTH-4){IRIN[3]}}, IRIN[3:0]};

    // Register reads: R0 is hardwired zero, a same-cycle writeback is bypassed through.
    always_comb begin
        rd_val = '0;
        rs_val = '0;
        rt_val = '0;
        if (rd_f != 4'd0) begin
            rd_val = (WB_EN && WB_ADDR == rd_f) ? WB_DATA : regs_q[rd_f];
        end
        if (rs_f != 4'd0) begin
            rs_val = (WB_EN && WB_ADDR == rs_f) ? WB_DATA : regs_q[rs_f];
        end
        if (rt_f != 4'd0) begin
            rt_val = (WB_EN && WB_ADDR == rt_f) ? WB_DATA : regs_q[rt_f];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (WB_EN && WB_ADDR != 4'd0) begin
            regs_d[WB_ADDR] = WB_DATA;
        end
    end

    always_comb begin
        a_dec    = '0;
        b_dec    = '0;
        imm_dec  = '0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        use_rd   = 1'b0;
        is_legal = 1'b1;
        is_halt  = 1'b0;
        case (op_f)
            OP_NOP: begin
            end
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                a_dec  = rs_val;
                b_dec  = rt_val;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_ADDI: begin
                a_dec   = rd_val;
                imm_dec = sext8;
                use_rd  = 1'b1;
            end
            OP_LOAD: begin
                a_dec   = rs_val;
                imm_dec = sext4;
                use_rs  = 1'b1;
            end
            OP_STORE: begin
                a_dec   = rs_val;
                b_dec   = rd_val;
                imm_dec = sext4;
                use_rs  = 1'b1;
                use_rd  = 1'b1;
            end
            OP_BEQZ: begin
                a_dec   = rd_val;
                imm_dec = sext8;
                use_rd  = 1'b1;
            end
            OP_JUMP: begin
                imm_dec = sext8;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
                is_legal = 1'b0;
            end
        endcase
    end

    // The bubble issued on a stall clears valid_q, so a stall can never outlast one cycle.
    assign hazard = VALID_IN && valid_q && (op_q == OP_LOAD) && (rd_q != 4'd0) &&
                    ((use_rs && rs_f == rd_q) || (use_rt && rt_f == rd_q) ||
                     (use_rd && rd_f == rd_q));

    assign STALL_OUT = !RST && !FLUSH && (halt_q || hazard);

    assign issue = VALID_IN && !FLUSH && !halt_q && !hazard && is_legal && !is_halt;

    always_comb begin
        halt_d  = halt_q || (VALID_IN && !FLUSH && is_halt);
        valid_d = issue;
        op_d    = issue ? op_f    : 4'd0;
        rd_d    = issue ? rd_f    : 4'd0;
        a_d     = issue ? a_dec   : '0;
        b_d     = issue ? b_dec   : '0;
        imm_d   = issue ? imm_dec : '0;
        pc_d    = issue ? PCIN    : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            regs_q  <= '0;
            valid_q <= 1'b0;
            op_q    <= 4'd0;
            rd_q    <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
        end
    end

    assign VALID_OUT = valid_q;
    assign OP_OUT    = op_q;
    assign RD_OUT    = rd_q;
    assign A_OUT     = a_q;
    assign B_OUT     = b_q;
    assign IMM_OUT   = imm_q;
    assign PC_OUT    = pc_q;
    assign HALT_OUT  = halt_q;

endmodule
